forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have these ports, each given as name, direction, width and meaning, with clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- ID_Valid  in  1  a real instruction is in decode
- ID_Rs, ID_Rt  in  5 each  source register numbers of the decode instruction
- ID_UsesRs, ID_UsesRt  in  1 each  the decode instruction reads that source
- ID_Rd  in  5  destination register of the decode instruction
- ID_RegWrite  in  1  the decode instruction writes ID_Rd
- ID_MemRead  in  1  the decode instruction is a load
- Flush  in  1  squash the decode instruction (branch taken)
- ForwardA, ForwardB  out  2 each  registered operand selects for the EX-stage 3-to-1 operand muxes
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- StallCount  out  16  saturating count of stall cycles
REQ-002 The select encoding SHALL be: 00 = register-file value, 01 = MEM/WB result, 10 = EX/MEM result, 11 = never driven.

Function
REQ-003 The block SHALL keep three shadow slots, EX, MEM and WB; each slot holds {valid, rd[4:0], regwrite, memread}.
REQ-004 Each non-reset clock edge SHALL shift the slots as follows: WB<-MEM, MEM<-EX, EX<-insert.
REQ-005 The insert SHALL be the ID fields when ID_Valid=1, Stall=0 and Flush=0; otherwise it SHALL be a bubble (valid=0, regwrite=0, memread=0, rd=0).
REQ-006 A slot SHALL be a forwarding source only if valid=1, regwrite=1 and rd != 0.
REQ-007 ForwardA's next value SHALL be computed from ID_Rs, ID_UsesRs and the current slot contents:
- 10 if the current EX slot is a source with rd == ID_Rs (this slot becomes EX/MEM);
- otherwise 01 if the current MEM slot is a source with rd == ID_Rs (this slot becomes MEM/WB);
- otherwise 00.
REQ-008 ForwardB SHALL follow REQ-007 exactly, using ID_Rt and ID_UsesRt.
REQ-009 The 10 result SHALL take priority over 01 when both slots match.
REQ-010 ForwardA and ForwardB SHALL be registered, taking their REQ-007/REQ-008 values when the inserted slot is a real instruction and 00 when it is a bubble, so they are valid during the whole cycle the instruction is in EX.
REQ-011 Stall SHALL be 1 exactly when all of the following hold:
- ID_Valid=1 and Flush=0;
- the EX slot has valid=1, memread=1, regwrite=1 and rd != 0;
- rd matches a used source (ID_Rs with ID_UsesRs, or ID_Rt with ID_UsesRt).
REQ-012 A load-use stall SHALL last exactly one cycle; in the following cycle the load sits in MEM, Stall=0, and the dependent instruction receives select 01.
REQ-013 Flush SHALL take priority over Stall: a flushed instruction SHALL insert a bubble with selects 00 and SHALL NOT raise Stall.
REQ-014 A source with its Uses flag at 0 SHALL produce select 00 and SHALL never cause a stall.
REQ-015 StallCount SHALL increment on each edge where Stall=1 and SHALL saturate at 16'hFFFF.
REQ-016 The block SHALL hold no other state; the latency from ID to the registered select is one clock.

Reset
REQ-017 While rst=1 the block SHALL asynchronously clear:
- all slot valid/regwrite/memread bits and rd fields to 0;
- ForwardA and ForwardB to 00;
- StallCount to 0.
REQ-018 While rst=1 the block SHALL force Stall=0, since all slots are invalid.
REQ-019 A reset asserted mid-stall SHALL drop the in-flight load; on the first edge after rst falls the decode instruction SHALL enter EX with selects 00.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- EX forward: add r3 (RegWrite) then sub using r3 as Rs on the next cycle -> ForwardA=10 and ForwardB=00 while sub is in EX.
- MEM forward: add r3, nop, then or using r3 as Rt -> ForwardB=01.
- Priority: add r4, add r4, then use r4 as both Rs and Rt -> ForwardA=ForwardB=10.
- Load-use: lw r5 then add using r5 as Rs -> Stall=1 for one cycle, StallCount 0->1, a bubble in EX with selects 00, then add in EX with ForwardA=01.
- r0 and flush: writer with rd=0 followed by a reader of r0 -> 00, no stall; lw r5 with the dependent instruction flushed -> Stall=0, bubble inserted.
- Reset mid-stall: rst pulsed while Stall=1 -> Stall=0, selects 00 and StallCount=0 immediately; the next instruction proceeds with no stall.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Purpose:
//   Forwarding and load-use hazard unit for a classic 5-stage pipeline. It
//   keeps its own shadow copy of the destination info for the instructions in
//   EX, MEM and WB. It uses that copy to do three things:
//     - compute registered operand-mux selects for the instruction that is
//       about to enter EX;
//     - raise a one-cycle combinational stall when a load result is needed
//       by the very next instruction;
//     - count stall cycles in a saturating counter.
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   ID_Valid     in   1   a real instruction is in decode
//   ID_Rs        in   5   first source register of the decode instruction
//   ID_Rt        in   5   second source register of the decode instruction
//   ID_UsesRs    in   1   decode instruction reads ID_Rs
//   ID_UsesRt    in   1   decode instruction reads ID_Rt
//   ID_Rd        in   5   destination register of the decode instruction
//   ID_RegWrite  in   1   decode instruction writes ID_Rd
//   ID_MemRead   in   1   decode instruction is a load
//   Flush        in   1   squash the decode instruction (taken branch)
//   ForwardA     out  2   registered EX operand-A select
//   ForwardB     out  2   registered EX operand-B select
//   Stall        out  1   combinational; hold PC and IF/ID this cycle
//   StallCount   out  16  saturating count of stall cycles
//
// Select encoding: 00 = register file, 01 = MEM/WB result,
//                  10 = EX/MEM result, 11 = never driven.
// -----------------------------------------------------------------------------
module forward_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        Flush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        Stall,
  output logic [15:0] StallCount
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  localparam int EX_IDX  = 0;
  localparam int MEM_IDX = 1;
  localparam int WB_IDX  = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  // Shadow pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  slot_t slot [3];

  slot_t      insert;
  logic       insert_real;
  logic       stall_c;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // A slot can supply a value only if it really writes a non-zero register.
  function automatic logic is_source(input slot_t s);
    return s.valid && s.regwrite && (s.rd != 5'd0);
  endfunction

  // EX/MEM result wins over MEM/WB because it is the younger write.
  function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                            input logic       uses,
                                            input slot_t      ex_s,
                                            input slot_t      mem_s);
    logic [1:0] sel;
    sel = SEL_RF;
    if (uses) begin
      if (is_source(ex_s) && (ex_s.rd == src))
        sel = SEL_EX;
      else if (is_source(mem_s) && (mem_s.rd == src))
        sel = SEL_MEM;
    end
    return sel;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Load-use detection: a load in EX cannot forward to the instruction now
  // in decode, so decode holds for one cycle while a bubble enters EX.
  always_comb begin
    stall_c = 1'b0;
    if (!rst && ID_Valid && !Flush &&
        slot[EX_IDX].memread && is_source(slot[EX_IDX])) begin
      if ((ID_UsesRs && (ID_Rs == slot[EX_IDX].rd)) ||
          (ID_UsesRt && (ID_Rt == slot[EX_IDX].rd)))
        stall_c = 1'b1;
    end
  end

  assign Stall = stall_c;

  // Flush and stall both turn the insert into a bubble.
  always_comb begin
    insert_real = ID_Valid && !stall_c && !Flush;
    insert      = '0;
    if (insert_real) begin
      insert.valid    = 1'b1;
      insert.rd       = ID_Rd;
      insert.regwrite = ID_RegWrite;
      insert.memread  = ID_MemRead;
    end
  end

  always_comb begin
    fwd_a_next = SEL_RF;
    fwd_b_next = SEL_RF;
    if (insert_real) begin
      fwd_a_next = fwd_select(ID_Rs, ID_UsesRs, slot[EX_IDX], slot[MEM_IDX]);
      fwd_b_next = fwd_select(ID_Rt, ID_UsesRt, slot[EX_IDX], slot[MEM_IDX]);
    end
  end

  // ID -> EX boundary: shift shadow slots and register selects and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        slot[i] <= '0;
      ForwardA   <= SEL_RF;
      ForwardB   <= SEL_RF;
      StallCount <= 16'd0;
    end else begin
      slot[WB_IDX]  <= slot[MEM_IDX];
      slot[MEM_IDX] <= slot[EX_IDX];
      slot[EX_IDX]  <= insert;
      ForwardA      <= fwd_a_next;
      ForwardB      <= fwd_b_next;
      if (stall_c)
        StallCount <= sat_inc16(StallCount);
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
//
// Directed bench for forward_hazard_unit: instruction sequences are driven
// into decode and the registered selects, stall and stall counter are compared
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

  logic        clk;
  logic        rst;
  logic        ID_Valid;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic [4:0]  ID_Rd;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        Flush;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;
  logic [15:0] StallCount;

  int vectors;
  int errors;

  forward_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ID_Valid    (ID_Valid),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRs   (ID_UsesRs),
    .ID_UsesRt   (ID_UsesRt),
    .ID_Rd       (ID_Rd),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .Flush       (Flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .Stall       (Stall),
    .StallCount  (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode-stage driver: valid, rs, rt, uses_rs, uses_rt, rd, regwrite, memread, flush.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    ID_Valid    = v;
    ID_Rs       = rs;
    ID_Rt       = rt;
    ID_UsesRs   = urs;
    ID_UsesRt   = urt;
    ID_Rd       = rd;
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    Flush       = fl;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop();
    repeat (2) step();
    vectors++;
    if (ForwardA !== 2'b00) begin
      $display("FAIL reset_fwda: got %b expected 00", ForwardA); errors++;
    end
    vectors++;
    if (ForwardB !== 2'b00) begin
      $display("FAIL reset_fwdb: got %b expected 00", ForwardB); errors++;
    end
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b expected 0", Stall); errors++;
    end
    vectors++;
    if (StallCount !== 16'd0) begin
      $display("FAIL reset_count: got %0d expected 0", StallCount); errors++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ex_forward();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); // sub r6,r3,r4
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL exfwd_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b10) begin
      $display("FAIL exfwd_fwda: got %b expected 10", ForwardA); errors++;
    end
    vectors++;
    if (ForwardB !== 2'b00) begin
      $display("FAIL exfwd_fwdb: got %b expected 00", ForwardB); errors++;
    end
    drain();
  endtask

  task automatic test_mem_forward();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); // add r3
    step();
    nop();
    step();
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); // or r7,r1,r3
    step();
    vectors++;
    if (ForwardB !== 2'b01) begin
      $display("FAIL memfwd_fwdb: got %b expected 01", ForwardB); errors++;
    end
    vectors++;
    if (ForwardA !== 2'b00) begin
      $display("FAIL memfwd_fwda: got %b expected 00", ForwardA); errors++;
    end
    drain();
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); // add r4
    step();
    drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); // add r4 again
    step();
    drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); // use r4 twice
    step();
    vectors++;
    if (ForwardA !== 2'b10) begin
      $display("FAIL prio_fwda: got %b expected 10", ForwardA); errors++;
    end
    vectors++;
    if (ForwardB !== 2'b10) begin
      $display("FAIL prio_fwdb: got %b expected 10", ForwardB); errors++;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); // add r8
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); // add r9
    step();
    drive(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    step();
    vectors++;
    if (ForwardA !== 2'b01) begin
      $display("FAIL b2b_fwda: got %b expected 01", ForwardA); errors++;
    end
    vectors++;
    if (ForwardB !== 2'b10) begin
      $display("FAIL b2b_fwdb: got %b expected 10", ForwardB); errors++;
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw r5
    step();
    drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); // add r7,r5,r2
    #1;
    vectors++;
    if (Stall !== 1'b1) begin
      $display("FAIL ldu_stall: got %b expected 1", Stall); errors++;
    end
    vectors++;
    if (StallCount !== 16'd0) begin
      $display("FAIL ldu_count_before: got %0d expected 0", StallCount); errors++;
    end
    step();
    vectors++;
    if (StallCount !== 16'd1) begin
      $display("FAIL ldu_count_after: got %0d expected 1", StallCount); errors++;
    end
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL ldu_bubble_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL ldu_stall_one_cycle: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b01) begin
      $display("FAIL ldu_fwda: got %b expected 01", ForwardA); errors++;
    end
    vectors++;
    if (ForwardB !== 2'b00) begin
      $display("FAIL ldu_fwdb: got %b expected 00", ForwardB); errors++;
    end
    vectors++;
    if (StallCount !== 16'd1) begin
      $display("FAIL ldu_count_hold: got %0d expected 1", StallCount); errors++;
    end
    drain();
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); // lw r0
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL r0_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL r0_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw r5
    step();
    drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1); // flushed add
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL flush_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL flush_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    vectors++;
    if (StallCount !== 16'd1) begin
      $display("FAIL flush_count: got %0d expected 1", StallCount); errors++;
    end
    // The load is now in MEM behind a bubble: a reader of r5 gets 01, no stall.
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL flush_next_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b01) begin
      $display("FAIL flush_next_fwda: got %b expected 01", ForwardA); errors++;
    end
    drain();
  endtask

  task automatic test_uses_off();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw r5
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL usesoff_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL usesoff_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw r5
    step();
    drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (Stall !== 1'b1) begin
      $display("FAIL rstmid_pre_stall: got %b expected 1", Stall); errors++;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL rstmid_stall: got %b expected 0", Stall); errors++;
    end
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL rstmid_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    vectors++;
    if (StallCount !== 16'd0) begin
      $display("FAIL rstmid_count: got %0d expected 0", StallCount); errors++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (Stall !== 1'b0) begin
      $display("FAIL rstmid_after_stall: got %b expected 0", Stall); errors++;
    end
    step();
    vectors++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      $display("FAIL rstmid_next_sel: got %b/%b expected 00/00", ForwardA, ForwardB); errors++;
    end
    vectors++;
    if (StallCount !== 16'd0) begin
      $display("FAIL rstmid_next_count: got %0d expected 0", StallCount); errors++;
    end
    drain();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    nop();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_priority();
    test_back_to_back();
    test_load_use();
    test_r0();
    test_flush();
    test_uses_off();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
